// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state names,
// opcode/funct constants, ALU operation codes and datapath mux encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_IMM_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Narrow base codes; zero-extended to the configured alu_ctrl width.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic       SRC_A_PC = 1'b0;
  localparam logic       SRC_A_RS = 1'b1;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: maps funct to an ALU operation and
// flags whether the funct is one the core implements.
module alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 5
) (
  input  logic [5:0]            funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  legal
);

  always_comb begin
    legal    = 1'b1;
    alu_ctrl = ALU_CTRL_W'(ALU_ADD);
    case (funct)
      FN_ADD:  alu_ctrl = ALU_CTRL_W'(ALU_ADD);
      FN_SUB:  alu_ctrl = ALU_CTRL_W'(ALU_SUB);
      FN_AND:  alu_ctrl = ALU_CTRL_W'(ALU_AND);
      FN_OR:   alu_ctrl = ALU_CTRL_W'(ALU_OR);
      FN_SLT:  alu_ctrl = ALU_CTRL_W'(ALU_SLT);
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM for lw/sw/R-type/beq/addi/j with a req/ready
// memory handshake and a retired-instruction counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    ins,
  input  logic                  mem_ready,
  input  logic                  zero,
  output logic                  mem_req,
  output logic                  memWrite,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  regWriteEnable,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic [1:0]            pc_source,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      retired,
  output state_t                state
);

  // Memory handshake: mem_req is held together with stable i_or_d/memWrite
  // until mem_ready is sampled high on a rising edge; the access completes in
  // that cycle. mem_ready is ignored whenever mem_req is low.

  state_t                  state_q, state_d;
  logic                    retire;
  logic [CNT_W-1:0]        retired_q;
  logic [5:0]              opcode, funct;
  logic [ALU_CTRL_W-1:0]   r_alu_ctrl;
  logic                    funct_legal;
  logic                    op_legal;
  logic                    unused_sig;

  assign opcode     = ins[INSTR_W-1 -: 6];
  assign funct      = ins[5:0];
  // zero is consumed by the datapath's PC write gate, not by the sequencing.
  assign unused_sig = ^{ins[INSTR_W-7:6], zero};

  alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .funct   (funct),
    .alu_ctrl(r_alu_ctrl),
    .legal   (funct_legal)
  );

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      OP_RTYPE:                            op_legal = funct_legal;
      default:                             op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!op_legal)                state_d = S_FETCH;
        else if (is_mem_op(opcode))   state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)  state_d = S_EXEC_R;
        else if (opcode == OP_BEQ)    state_d = S_BRANCH;
        else if (opcode == OP_ADDI)   state_d = S_EXEC_I;
        else                          state_d = S_JUMP;
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: state_d = S_ALU_WB;
      S_EXEC_I: state_d = S_IMM_WB;
      S_MEM_WB, S_ALU_WB, S_IMM_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates every strobe so an in-flight access is dropped immediately.
  always_comb begin
    mem_req        = 1'b0;
    memWrite       = 1'b0;
    i_or_d         = 1'b0;
    ir_write       = 1'b0;
    regWriteEnable = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    alu_src_a      = SRC_A_PC;
    alu_src_b      = SRC_B_RT;
    alu_ctrl       = ALU_CTRL_W'(ALU_ADD);
    pc_write       = 1'b0;
    pc_write_cond  = 1'b0;
    pc_source      = PC_SRC_ALU;
    illegal_op     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = SRC_B_IMM_SH;
          illegal_op = !op_legal;
        end
        S_MEM_ADDR, S_EXEC_I: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_IMM;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_MEM_WB: begin
          regWriteEnable = 1'b1;
          mem_to_reg     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req  = 1'b1;
          memWrite = 1'b1;
          i_or_d   = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS;
          alu_ctrl  = r_alu_ctrl;
        end
        S_ALU_WB: begin
          regWriteEnable = 1'b1;
          reg_dst        = 1'b1;
        end
        S_IMM_WB: regWriteEnable = 1'b1;
        S_BRANCH: begin
          alu_src_a     = SRC_A_RS;
          alu_ctrl      = ALU_CTRL_W'(ALU_SUB);
          pc_write_cond = 1'b1;
          pc_source     = PC_SRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a
// randomized instruction stream against a per-instruction behavioural model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  localparam int CW = 8;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   ins;
  logic          mem_ready;
  logic          zero;
  logic          mem_req, memWrite, i_or_d, ir_write, regWriteEnable;
  logic          reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]    alu_src_b, pc_source;
  logic [4:0]    alu_ctrl;
  logic          pc_write, pc_write_cond, illegal_op;
  logic [CW-1:0] retired;
  state_t        state;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_retired = '0;

  multicycle_control #(.INSTR_W(32), .ALU_CTRL_W(5), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ins(ins), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .memWrite(memWrite), .i_or_d(i_or_d), .ir_write(ir_write),
    .regWriteEnable(regWriteEnable), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .illegal_op(illegal_op), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  // ---- reference model: instruction class, latency and ALU op ----
  function automatic int exp_alu(input logic [5:0] f);
    if (f == 6'h20) return 0;
    if (f == 6'h22) return 1;
    if (f == 6'h24) return 2;
    if (f == 6'h25) return 3;
    if (f == 6'h2A) return 4;
    return -1;
  endfunction

  function automatic int kind_of(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h08) return K_ADDI;
    if (op == 6'h02) return K_J;
    if (op == 6'h00 && exp_alu(w[5:0]) >= 0) return K_R;
    return K_ILL;
  endfunction

  function automatic int base_latency(input int k);
    int lat[7] = '{5, 4, 4, 4, 3, 3, 2};
    return lat[k];
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k;
    logic [5:0]  op, fn;
    logic [5:0]  fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [31:0] w;
    k = $urandom_range(0, 6);
    w = $urandom();
    case (k)
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_ADDI: op = 6'h08;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_R: begin
        op = 6'h00;
        w[5:0] = fns[$urandom_range(0, 4)];
      end
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          op = 6'h00;
          do fn = 6'($urandom()); while (exp_alu(fn) >= 0);
          w[5:0] = fn;
        end else begin
          do op = 6'($urandom());
          while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02);
        end
      end
    endcase
    w[31:26] = op;
    return w;
  endfunction

  // Drive one instruction from FETCH back to FETCH and compare observations.
  task automatic run_instr(input logic [31:0] w, input int fw, input int dw, input string tag);
    int k, lat, cyc, fw_left, dw_left;
    int ir_cnt, ir_cyc, wr_cnt, wr_cyc, mw_cnt, mr_cnt, il_cnt, pwc_cnt, jmp_cnt, ex_cnt, ex_alu;
    logic wr_m2r, wr_dst, done, is_mem;
    logic [1:0] pwc_src;
    k = kind_of(w);
    is_mem = (k == K_LW || k == K_SW);
    lat = base_latency(k) + fw + (is_mem ? dw : 0);
    {cyc, ir_cnt, ir_cyc, wr_cnt, wr_cyc, mw_cnt, mr_cnt, il_cnt, pwc_cnt, jmp_cnt, ex_cnt, ex_alu} = '0;
    wr_m2r = 0; wr_dst = 0; pwc_src = 0; done = 0;
    fw_left = fw; dw_left = dw;
    ins = w;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (mem_req && !i_or_d) begin
        mem_ready = (fw_left == 0);
        if (fw_left > 0) fw_left--;
      end else if (mem_req) begin
        mem_ready = (dw_left == 0);
        if (dw_left > 0) dw_left--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      zero = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (ir_write) begin ir_cnt++; if (ir_cyc == 0) ir_cyc = cyc; end
      if (regWriteEnable) begin wr_cnt++; wr_cyc = cyc; wr_m2r = mem_to_reg; wr_dst = reg_dst; end
      if (memWrite) mw_cnt++;
      if (mem_req) mr_cnt++;
      if (illegal_op) il_cnt++;
      if (pc_write_cond) begin pwc_cnt++; pwc_src = pc_source; end
      if (pc_write && pc_source == 2'd2) jmp_cnt++;
      if (alu_src_a && alu_src_b == 2'd0 && !pc_write_cond) begin ex_cnt++; ex_alu = int'(alu_ctrl); end
      @(posedge clk);
      #1;
      if (ir_cnt > 0 && state == S_FETCH) done = 1;
    end
    if (k != K_ILL) exp_retired = exp_retired + 1'b1;

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: ins=%h never returned to fetch after %0d cycles", tag, w, cyc);
      return;
    end
    checks++; if (cyc !== lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, lat); end
    checks++; if (ir_cnt !== 1 || ir_cyc !== fw + 1) begin errors++; $display("FAIL %s ir_write: count %0d at cycle %0d, expected 1 at %0d", tag, ir_cnt, ir_cyc, fw + 1); end
    checks++;
    if (k == K_LW || k == K_R || k == K_ADDI) begin
      if (wr_cnt !== 1 || wr_cyc !== lat || wr_m2r !== (k == K_LW) || wr_dst !== (k == K_R)) begin
        errors++;
        $display("FAIL %s regwrite: count %0d cyc %0d m2r %0b dst %0b, expected 1 %0d %0b %0b", tag, wr_cnt, wr_cyc, wr_m2r, wr_dst, lat, k == K_LW, k == K_R);
      end
    end else if (wr_cnt !== 0) begin
      errors++; $display("FAIL %s regwrite: count %0d expected 0", tag, wr_cnt);
    end
    checks++; if (mw_cnt !== ((k == K_SW) ? dw + 1 : 0)) begin errors++; $display("FAIL %s memWrite cycles: got %0d expected %0d", tag, mw_cnt, (k == K_SW) ? dw + 1 : 0); end
    checks++; if (mr_cnt !== fw + 1 + (is_mem ? dw + 1 : 0)) begin errors++; $display("FAIL %s mem_req cycles: got %0d expected %0d", tag, mr_cnt, fw + 1 + (is_mem ? dw + 1 : 0)); end
    checks++; if (il_cnt !== ((k == K_ILL) ? 1 : 0)) begin errors++; $display("FAIL %s illegal_op cycles: got %0d expected %0d", tag, il_cnt, (k == K_ILL) ? 1 : 0); end
    checks++; if (pwc_cnt !== ((k == K_BEQ) ? 1 : 0) || (k == K_BEQ && pwc_src !== 2'd1)) begin errors++; $display("FAIL %s branch: pc_write_cond cycles %0d pc_source %0d, expected %0d and 1", tag, pwc_cnt, pwc_src, (k == K_BEQ) ? 1 : 0); end
    checks++; if (jmp_cnt !== ((k == K_J) ? 1 : 0)) begin errors++; $display("FAIL %s jump: pc_write/pc_source=2 cycles %0d expected %0d", tag, jmp_cnt, (k == K_J) ? 1 : 0); end
    checks++;
    if (k == K_R) begin
      if (ex_cnt !== 1 || ex_alu !== exp_alu(w[5:0])) begin errors++; $display("FAIL %s exec alu_ctrl: count %0d value %0d expected 1 and %0d", tag, ex_cnt, ex_alu, exp_alu(w[5:0])); end
    end else if (ex_cnt !== 0) begin
      errors++; $display("FAIL %s exec: unexpected register-register ALU cycles %0d", tag, ex_cnt);
    end
    checks++; if (retired !== exp_retired) begin errors++; $display("FAIL %s retired: got %0d expected %0d", tag, retired, exp_retired); end
  endtask

  task automatic test_reset();
    reset = 1'b1; ins = '0; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (retired !== '0) begin errors++; $display("FAIL reset retired: got %0d expected 0", retired); end
    checks++; if (state !== S_FETCH) begin errors++; $display("FAIL reset state: got %0d expected FETCH", state); end
    checks++; if ({mem_req, memWrite, ir_write, regWriteEnable, pc_write, illegal_op} !== 6'b0) begin errors++; $display("FAIL reset strobes: got %b expected 000000", {mem_req, memWrite, ir_write, regWriteEnable, pc_write, illegal_op}); end
    reset = 1'b0;
    exp_retired = '0;
    #1;
    checks++; if (mem_req !== 1'b1 || alu_src_b !== 2'd1 || i_or_d !== 1'b0) begin errors++; $display("FAIL fetch outputs: mem_req %0b alu_src_b %0d i_or_d %0b expected 1 1 0", mem_req, alu_src_b, i_or_d); end
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    run_instr(32'h8C080004, 0, 0, "lw");
    run_instr(32'h8C080004, 2, 3, "lw_wait");
  endtask

  task automatic test_sw();
    run_instr(32'hAC080004, 0, 3, "sw_wait");
    run_instr(32'hAC080004, 1, 0, "sw");
  endtask

  task automatic test_rtype();
    run_instr(32'h01095020, 0, 0, "add");
    run_instr(32'h01095022, 0, 0, "sub");
    run_instr(32'h0109502A, 0, 0, "slt");
    run_instr(32'h0109502C, 0, 0, "bad_funct");
  endtask

  task automatic test_branch_jump();
    run_instr(32'h11090003, 0, 0, "beq");
    run_instr(32'h08000010, 0, 0, "j");
    run_instr(32'h21090007, 1, 0, "addi");
  endtask

  task automatic test_illegal();
    run_instr(32'hFC000000, 0, 0, "illegal");
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), "random");
  endtask

  task automatic test_reset_mid_write();
    int guard;
    ins = 32'hAC080004;
    guard = 0;
    while (state != S_MEM_WRITE && guard < 20) begin
      @(negedge clk);
      mem_ready = (state == S_FETCH);
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (state != S_MEM_WRITE) begin
      errors++; $display("FAIL reset_mid timeout: never reached memory write");
      return;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++; if (memWrite !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL reset_mid pre: memWrite %0b mem_req %0b expected 1 1", memWrite, mem_req); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || memWrite !== 1'b0) begin errors++; $display("FAIL reset_mid strobes: mem_req %0b memWrite %0b expected 0 0", mem_req, memWrite); end
    checks++; if (state !== S_FETCH) begin errors++; $display("FAIL reset_mid state: got %0d expected FETCH", state); end
    checks++; if (retired !== '0) begin errors++; $display("FAIL reset_mid retired: got %0d expected 0", retired); end
    exp_retired = '0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (exp_retired != {CW{1'b1}} && guard < 300) begin
      run_instr(32'h08000010, 0, 0, "wrap_fill");
      guard++;
    end
    checks++; if (retired !== {CW{1'b1}}) begin errors++; $display("FAIL wrap pre: retired %0d expected all ones", retired); end
    run_instr(32'h01095020, 0, 0, "wrap_step");
    checks++; if (retired !== '0) begin errors++; $display("FAIL wrap: retired %0d expected 0", retired); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_branch_jump();
    test_illegal();
    test_random();
    test_reset_mid_write();
    test_lw();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised successor to the single-cycle lw/sw decoder: a multi-cycle MIPS control FSM.
- Sequences fetch, decode, execute, memory and writeback over several cycles for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
- Supports variable-latency memory through a req/ready handshake.
- Drives the shared-datapath muxes, the register-file write enable, memory strobes and a retired-instruction counter.

Parameters:
- INSTR_W, 32, instruction width; opcode = ins[INSTR_W-1 -: 6], funct = ins[5:0].
- ALU_CTRL_W, 5, width of alu_ctrl; matches the existing alu4..alu0 bundle.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ins  in  INSTR_W  current instruction from the external IR.
- mem_ready  in  1  memory completes the access this cycle.
- zero  in  1  ALU zero flag (beq).
- mem_req  out  1  memory access request.
- memWrite  out  1  write strobe, qualified by mem_req.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- regWriteEnable  out  1  register-file write.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = imm<<2.
- alu_ctrl  out  ALU_CTRL_W  ALU operation.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode/funct.
- retired  out  CNT_W  completed-instruction count.

Behaviour:
- Reset (async, active-high) forces state FETCH, retired = 0, and every registered output low. Outputs are combinational from state and ins.
- Outputs not listed for a state are 0.
- FETCH:
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=0, next state DECODE.
  - Otherwise holds FETCH with ir_write=0 and pc_write=0.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, alu_ctrl=ADD to precompute the branch target.
  - Next state by opcode:
    - lw (100011) or sw (101011) -> MEM_ADDR.
    - R-type (000000) with a legal funct -> EXEC_R.
    - beq (000100) -> BRANCH.
    - addi (001000) -> EXEC_I.
    - j (000010) -> JUMP.
    - Anything else -> illegal_op=1, next state FETCH, no retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_ctrl=ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_req=1, i_or_d=1. Holds until mem_ready=1, then -> MEM_WB.
- MEM_WB: regWriteEnable=1, reg_dst=0, mem_to_reg=1. Retire; -> FETCH.
- MEM_WRITE: mem_req=1, memWrite=1, i_or_d=1. Holds while mem_ready=0. On mem_ready=1: retire; -> FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. -> ALU_WB.
- ALU_WB: regWriteEnable=1, reg_dst=1, mem_to_reg=0. Retire; -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_ctrl=ADD. -> IMM_WB.
- IMM_WB: regWriteEnable=1, reg_dst=0, mem_to_reg=0. Retire; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_ctrl=SUB, pc_write_cond=1, pc_source=1. Retire; -> FETCH.
- JUMP: pc_write=1, pc_source=2. Retire; -> FETCH.
- Latency in cycles, with every mem_ready=1 on first request: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each cycle mem_ready is low adds one cycle.
- "Retire" means retired increments by 1 on the transition into FETCH. It wraps modulo 2^CNT_W with no flag.
- Holding states: mem_req and memWrite stay asserted, and the address selects stay stable, until mem_ready is sampled high.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Async reset mid-access drops mem_req and memWrite immediately. The counter is cleared and the in-flight instruction is not retired.
- Encodings ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4, zero-extended to ALU_CTRL_W.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - State enum.
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - Funct constants.
  - ALU_* encodings.
  - alu_src_b and pc_source encodings.
- One sub-module, alu_decoder: combinational funct -> alu_ctrl plus a legal flag. It is reused by the later pipelined core.

Test Plan:
- Reset mid-MEM_WRITE with mem_ready=0 -> mem_req and memWrite low in the same cycle, state FETCH, retired=0.
- lw (0x8C080004), mem_ready always 1 -> ir_write at cycle 1; regWriteEnable=1 with mem_to_reg=1 and reg_dst=0 at cycle 5; retired=1.
- sw (0xAC080004), mem_ready held low 3 cycles in MEM_WRITE -> memWrite high exactly 4 cycles; retired increments once.
- add (0x01095020), then sub (0x01095022), then slt (0x0109502A) -> alu_ctrl 0, 1, 4 in EXEC_R; reg_dst=1 in ALU_WB; retired=3.
- beq (0x11090003), then j (0x08000010) -> BRANCH shows pc_write_cond=1 with pc_source=1; JUMP shows pc_write=1 with pc_source=2; 3 cycles each.
- Opcode 111111 -> illegal_op pulses one cycle in DECODE, back to FETCH, retired unchanged. Separately, force retired to all-ones and retire one instruction -> wraps to 0.
